// File: rtl/bcd_updown_counter_if.sv
// Control/data bundle for bcd_updown_counter: the master drives the controls
// and load value, the slave (the counter) returns the count and status flags.
interface bcd_updown_counter_if #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned DIGIT_WIDTH = 4
);
    logic                          i_clr;
    logic                          i_load;
    logic [DIGITS*DIGIT_WIDTH-1:0] i_load_val;
    logic                          i_en;
    logic                          i_up;
    logic [DIGITS*DIGIT_WIDTH-1:0] o_cnt;
    logic                          o_tc;
    logic                          o_zero;
    logic                          o_ovf;
    logic                          o_load_err;

    modport master (
        output i_clr,
        output i_load,
        output i_load_val,
        output i_en,
        output i_up,
        input  o_cnt,
        input  o_tc,
        input  o_zero,
        input  o_ovf,
        input  o_load_err
    );

    modport slave (
        input  i_clr,
        input  i_load,
        input  i_load_val,
        input  i_en,
        input  i_up,
        output o_cnt,
        output o_tc,
        output o_zero,
        output o_ovf,
        output o_load_err
    );
endinterface

// File: rtl/bcd_updown_counter.sv
// Multi-digit up/down modulo counter with synchronous clear, clamped parallel
// load and wrap or saturate behaviour at the ends of the range.
// Digit 0 occupies the LSBs of the packed count.
module bcd_updown_counter #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned MODULO      = 10,
    parameter int unsigned DIGIT_WIDTH = $clog2(MODULO),
    parameter bit          WRAP_MODE   = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    bcd_updown_counter_if.slave  bus
);
    typedef logic [DIGIT_WIDTH-1:0] digit_t;

    localparam digit_t MAX_DIGIT = digit_t'(MODULO - 1);
    localparam digit_t ONE       = digit_t'(1);

    digit_t [DIGITS-1:0] cnt_q;
    digit_t [DIGITS-1:0] cnt_d;
    digit_t [DIGITS-1:0] step_val;
    digit_t [DIGITS-1:0] load_clamped;
    logic                ovf_q;
    logic                ovf_d;
    logic                err_q;
    logic                err_d;

    logic [DIGITS-1:0] is_max;
    logic [DIGITS-1:0] is_min;
    logic [DIGITS-1:0] load_bad;
    logic [DIGITS-1:0] carry_in;
    logic [DIGITS-1:0] borrow_in;
    logic              all_max;
    logic              all_zero;
    logic              at_end;

    // Per-digit carry/borrow chain, load clamp and step value.
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        // Selects digits 0..k-1; digit k steps only when all lower digits are at their limit.
        localparam logic [DIGITS-1:0] LOW_MASK = {DIGITS{1'b1}} >> (DIGITS - k);

        digit_t load_dig;
        digit_t inc_val;
        digit_t dec_val;

        assign is_max[k] = (cnt_q[k] == MAX_DIGIT);
        assign is_min[k] = (cnt_q[k] == '0);

        assign carry_in[k]  = &(is_max | ~LOW_MASK);
        assign borrow_in[k] = &(is_min | ~LOW_MASK);

        assign inc_val = is_max[k] ? '0 : cnt_q[k] + ONE;
        assign dec_val = is_min[k] ? MAX_DIGIT : cnt_q[k] - ONE;

        assign step_val[k] = bus.i_up ? (carry_in[k]  ? inc_val : cnt_q[k])
                                      : (borrow_in[k] ? dec_val : cnt_q[k]);

        assign load_dig        = bus.i_load_val[k*DIGIT_WIDTH +: DIGIT_WIDTH];
        assign load_bad[k]     = (load_dig > MAX_DIGIT);
        assign load_clamped[k] = load_bad[k] ? MAX_DIGIT : load_dig;
    end

    assign all_max  = &is_max;
    assign all_zero = &is_min;
    assign at_end   = bus.i_up ? all_max : all_zero;

    // Next-state selection: clear beats load beats count beats hold.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        err_d = 1'b0;
        if (bus.i_clr) begin
            cnt_d = '0;
        end else if (bus.i_load) begin
            cnt_d = load_clamped;
            err_d = |load_bad;
        end else if (bus.i_en) begin
            ovf_d = at_end;
            // In saturate mode an end-of-range step is blocked and the count holds.
            if (!at_end || WRAP_MODE) begin
                cnt_d = step_val;
            end
        end
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            err_q <= err_d;
        end
    end

    assign bus.o_cnt      = cnt_q;
    assign bus.o_tc       = bus.i_en & at_end;
    assign bus.o_zero     = all_zero;
    assign bus.o_ovf      = ovf_q;
    assign bus.o_load_err = err_q;
endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
- Parametrised multi-digit modulo counter: DIGITS cascaded digits, each counting 0..MODULO-1. Adds up/down counting, synchronous clear, parallel load and wrap/saturate mode.
- Each digit carries or borrows into the next.
- Used by the calculator datapath and UI for digit-cursor positions, entry-length counting and decimal step counters.
- Output o_cnt is packed, digit 0 in the LSBs.

Parameters:
- DIGITS, 4, number of cascaded digits (>=1).
- MODULO, 10, radix of every digit (>=2).
- DIGIT_WIDTH, $clog2(MODULO), bits per digit. Must be >=1 (MODULO=2 gives 1).
- WRAP_MODE, 1: 1 = wrap at the ends of the range; 0 = saturate at the ends.

Ports:
- i_clk, input, 1, the single clock. All state updates on its rising edge.
- i_rst, input, 1, reset. Asynchronous, active-high, clears all state immediately.
- i_clr, input, 1, synchronous clear to zero.
- i_load, input, 1, synchronous parallel load from i_load_val.
- i_load_val, input, DIGITS*DIGIT_WIDTH, load value, digit 0 in the LSBs.
- i_en, input, 1, count enable; one step per cycle when high.
- i_up, input, 1, direction: 1 = increment, 0 = decrement.
- o_cnt, output, DIGITS*DIGIT_WIDTH, registered count.
- o_tc, output, 1, combinational terminal count. High = i_en & ((i_up & all digits == MODULO-1) | (!i_up & all digits == 0)).
- o_zero, output, 1, combinational: all digits == 0.
- o_ovf, output, 1, registered one-cycle pulse. Flags that the previous enabled step hit the end of the range (wrapped or was blocked by saturation).
- o_load_err, output, 1, registered one-cycle pulse. Flags that the previous load contained at least one digit >= MODULO.

Behaviour:
- Reset: i_rst high forces o_cnt=0, o_ovf=0, o_load_err=0 asynchronously and holds them while asserted. The first update after release occurs on the next rising edge.
- Priority per edge: i_clr > i_load > i_en > hold.
  - i_clr: all digits become 0. o_ovf=0, o_load_err=0.
  - i_load: each digit d gets i_load_val digit d if < MODULO, else MODULO-1. o_load_err = 1 if any digit was clamped. o_ovf=0.
  - i_en: one step in direction i_up (see counting rules below).
  - Otherwise: o_cnt holds. o_ovf=0, o_load_err=0.
- Counting up:
  - Digit 0 increments.
  - Digit k increments only when digits 0..k-1 all equal MODULO-1. A digit at MODULO-1 that increments becomes 0 (ripple carry, same cycle).
- Counting down:
  - Digit 0 decrements.
  - Digit k decrements only when digits 0..k-1 all equal 0. A digit at 0 that decrements becomes MODULO-1.
- Terminal count (o_tc high on an enabled step):
  - WRAP_MODE=1: up wraps all-max to all-zero; down wraps all-zero to all-max.
  - WRAP_MODE=0: o_cnt holds.
  - In both modes o_ovf=1 on the following cycle.
- Latency: o_cnt reflects a clr/load/step one edge after the control is sampled. o_tc and o_zero follow o_cnt and inputs combinationally. o_ovf and o_load_err update on the same edge as o_cnt.
- Direction changes between cycles are legal, with no dead cycle.
- Digits are never outside 0..MODULO-1 after reset.
- Reset asserted mid-count discards the count. No state survives reset.
- DIGITS=1 reduces to a single up/down modulo counter.
- Non-power-of-two MODULO: codes MODULO..2^DIGIT_WIDTH-1 are unreachable.
- Implementation: one register bank plus next-state logic per digit; a generate loop for the carry/borrow chain. No multipliers or dividers.

Test Plan (DIGITS=3, MODULO=10 unless stated):
- Reset with i_en=1 held, release i_rst, i_up=1 for 12 edges: o_cnt = 0x000 then 0x001..0x009, 0x010, 0x011, 0x012. Assert i_rst asynchronously mid-cycle: o_cnt=0 before the next edge.
- Load 0x998, count up 3 edges (WRAP_MODE=1): 0x999 with o_tc=1 before the edge, then 0x000 with o_ovf=1 for one cycle, then 0x001 with o_ovf=0.
- WRAP_MODE=0, o_cnt=0x000, i_up=0, i_en=1 for 2 edges: o_cnt stays 0x000; o_zero=1, o_tc=1; o_ovf=1 on each following cycle. Switch i_up=1: next value 0x001.
- Load 0x100, count down one edge: 0x099 (borrow through two digits). Count down again: 0x098.
- Load i_load_val=0xA3F: o_cnt=0x939 (illegal digits clamped to 9), o_load_err=1 for exactly one cycle.
- i_clr, i_load and i_en all high together with o_cnt=0x555: o_cnt=0x000, o_ovf=0, o_load_err=0. Then i_load and i_en high with 0x123: o_cnt=0x123, not 0x124.
